// File: rtl/regfile_debug_arbiter.sv
// Debug-port arbiter for the decode-stage register file: halts the pipeline,
// drains in-flight writebacks, then performs one debug read or write.
module regfile_debug_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DRAIN_CYCLES   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dbg_req_i,
    input  logic                      dbg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]     dbg_wdata_i,
    input  logic                      dbg_hold_i,
    output logic                      dbg_ack_o,
    output logic [DATA_WIDTH-1:0]     dbg_rdata_o,
    output logic                      halted_o,
    input  logic                      rd_write_en_wb_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_wb_i,
    input  logic [DATA_WIDTH-1:0]     rd_data_wb_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id_i,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr_o,
    input  logic [DATA_WIDTH-1:0]     rf_rs1_data_i
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ACK    = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    halted_q, ack_q;

    // Next-state, drain counter and read-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_RUN: begin
                if (dbg_req_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 4'(DRAIN_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                // A late writeback owns the write port; only a debug write waits.
                if (!dbg_we_i) begin
                    rdata_d = rf_rs1_data_i;
                    state_d = ST_ACK;
                end else if (rd_write_en_wb_i) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (dbg_hold_i) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (dbg_req_i) begin
                    state_d = ST_ACCESS;
                end else if (!dbg_hold_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Register-file port muxes: pass-through except during the debug access.
    always_comb begin
        rf_we_o       = rd_write_en_wb_i;
        rf_waddr_o    = rd_addr_wb_i;
        rf_wdata_o    = rd_data_wb_i;
        rf_rs1_addr_o = rs1_addr_id_i;
        if (state_q == ST_ACCESS) begin
            if (!dbg_we_i) begin
                rf_rs1_addr_o = dbg_addr_i;
            end else if (!rd_write_en_wb_i) begin
                rf_we_o    = (dbg_addr_i != {REG_ADDR_WIDTH{1'b0}});
                rf_waddr_o = dbg_addr_i;
                rf_wdata_o = dbg_wdata_i;
            end else begin
                rf_we_o = rd_write_en_wb_i;
            end
        end else begin
            rf_rs1_addr_o = rs1_addr_id_i;
        end
    end

    // State, counter and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= 4'd0;
            rdata_q  <= {DATA_WIDTH{1'b0}};
            halted_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            halted_q <= (state_d != ST_RUN);
            ack_q    <= (state_d == ST_ACK);
        end
    end

    assign halted_o    = halted_q;
    assign dbg_ack_o   = ack_q;
    assign dbg_rdata_o = rdata_q;

endmodule
